serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder: the addition counterpart of the team's gate-level subtractor blocks.
- Computes WIDTH-bit a + b + cin by processing one bit per clock through a single 1-bit full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake.
- Sits beside the combinational arithmetic blocks as the area-minimal sequential adder for datapaths that tolerate WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new addition; sampled on rising clk when busy=0
a  input  WIDTH  operand A; captured on an accepted start
b  input  WIDTH  operand B; captured on an accepted start
cin  input  1  carry-in; captured on an accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: sum and cout are valid for the new result
sum  output  WIDTH  registered result; holds its value until the next completion
cout  output  1  registered carry-out of the MSB; holds with sum

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal a/b/sum shift registers, carry flop and bit counter are all cleared.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE.
- Accepting a start:
  - An edge with start=1 in IDLE or DONE loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, and moves to RUN.
  - start is ignored in RUN; no queuing, no error flag.
- RUN, each edge:
  - Full-adder cell takes a_sh[0], b_sh[0], carry and produces (s, co).
  - a_sh and b_sh shift right by one.
  - s_sh <= {s, s_sh[WIDTH-1:1]} (LSB-first result, MSB-side insertion).
  - carry <= co; cnt <= cnt+1.
- Completion edge (cnt==WIDTH-1 in RUN):
  - sum <= {s, s_sh[WIDTH-1:1]}; cout <= co.
  - Move to DONE.
  - sum/cout change only on this edge.
- DONE lasts exactly one cycle:
  - Next edge goes to IDLE, or to RUN if start=1 (back-to-back operation).
  - done drops in either case.
- Latency: start accepted at edge E gives done=1 in the cycle following edge E+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Widths:
  - cnt is CNT_W = ceil(log2(WIDTH)) bits, computed as a localparam by constant function.
  - The result is modulo 2^WIDTH; the overflow bit appears only on cout.
- Boundaries:
  - Operands changing after acceptance have no effect.
  - All-ones + all-ones + cin=1 yields all-ones with cout=1.
  - rst asserted mid-RUN aborts immediately: no done pulse, sum/cout return to 0.
- No X propagation from the idle inputs a/b/cin while not accepting.

Decomposition:
- Shared header (serial_arith_defs.vh): state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2, and the clog2 constant function. Other serial arithmetic blocks reuse both.
- One sub-module: full_adder_cell. Purely combinational (x, y, ci -> s, co), instantiated once.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8, reset, then start with a=8'h35, b=8'h4A, cin=0 -> busy for 8 cycles; done pulses once at cycle 9 after the start edge; sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Follow with a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start a=8'h10, b=8'h20, then pulse start with a=8'h01, b=8'h01 at cycle 3 of RUN -> second start ignored; exactly one done; sum=8'h30.
- Start 8'h0F+8'h01; assert rst at cycle 4 of RUN -> busy=0, sum=0, no done. After release, start 8'h0F+8'h01 -> sum=8'h10, cout=0.
- Hold start=1 continuously with a=8'h80, b=8'h80, cin=0 -> done pulses every 9 cycles; each result sum=8'h00, cout=1; busy low only in DONE cycles.
- Randomized 1000 operations at WIDTH=8 and WIDTH=16 against a reference model {cout,sum} = a+b+cin -> zero mismatches.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: state encoding and
// a constant ceil(log2) helper for sizing bit counters.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first,
// WIDTH cycles per result with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last;

  full_adder_cell u_fa (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      S_IDLE: begin
        accept = start;
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        last = (cnt == LAST);
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        accept = start;
        state_nx = start ? S_RUN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operands are only sampled on an accepted start, so idle inputs never leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_s, s_sh[WIDTH-1:1]};
        cout <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  // Drive one WIDTH=8 operation and observe a fixed window; optionally pulse
  // a second start at RUN cycle inj_k to show it is ignored.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input int inj_k, input logic [7:0] ia, input logic [7:0] ib,
                         output int done_k, output int ndone, output int nbusy,
                         output logic [7:0] rs, output logic rc);
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    done_k = 0; ndone = 0; nbusy = 0; rs = '0; rc = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
      if (k == inj_k) begin start8 = 1'b1; a8 = ia; b8 = ib; end
      if (busy8) nbusy++;
      if (done8) begin
        ndone++;
        if (done_k == 0) begin done_k = k; rs = sum8; rc = cout8; end
      end
    end
  endtask

  task automatic check_op8(input string name, input logic [7:0] ta, input logic [7:0] tb,
                           input logic tc, input int inj_k, input logic [7:0] ia,
                           input logic [7:0] ib, input logic [7:0] es, input logic ec);
    int dk, nd, nb;
    logic [7:0] rs;
    logic rc;
    run_op8(ta, tb, tc, inj_k, ia, ib, dk, nd, nb, rs, rc);
    checks++;
    if (dk !== 9) begin failures++; $display("FAIL %s latency got=%0d exp=9", name, dk); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL %s done_count got=%0d exp=1", name, nd); end
    checks++;
    if (nb !== 8) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=8", name, nb); end
    checks++;
    if ({rc, rs} !== {ec, es}) begin
      failures++;
      $display("FAIL %s result got=%0b_%h exp=%0b_%h", name, rc, rs, ec, es);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      failures++; $display("FAIL reset8 got busy=%b done=%b cout=%b sum=%h exp=0", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy16, done16, cout16, sum16} !== 19'd0) begin
      failures++; $display("FAIL reset16 got busy=%b done=%b cout=%b sum=%h exp=0", busy16, done16, cout16, sum16);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_op8("basic_35_4a", 8'h35, 8'h4A, 1'b0, 0, 8'h00, 8'h00, 8'h7F, 1'b0);
    check_op8("ff_01",       8'hFF, 8'h01, 1'b0, 0, 8'h00, 8'h00, 8'h00, 1'b1);
    check_op8("ff_ff_c1",    8'hFF, 8'hFF, 1'b1, 0, 8'h00, 8'h00, 8'hFF, 1'b1);
  endtask

  task automatic test_start_ignored();
    check_op8("start_in_run", 8'h10, 8'h20, 1'b0, 3, 8'h01, 8'h01, 8'h30, 1'b0);
  endtask

  task automatic test_abort();
    int nd;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      failures++; $display("FAIL abort got busy=%b done=%b cout=%b sum=%h exp=0", busy8, done8, cout8, sum8);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) nd++;
    end
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
    check_op8("after_abort", 8'h0F, 8'h01, 1'b0, 0, 8'h00, 8'h00, 8'h10, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit exp_done;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_done = (k % 9) == 0;
      checks++;
      if (done8 !== exp_done || busy8 !== !exp_done) begin
        failures++;
        $display("FAIL b2b_handshake k=%0d got done=%b busy=%b exp done=%b busy=%b",
                 k, done8, busy8, exp_done, !exp_done);
      end
      if (exp_done) begin
        checks++;
        if ({cout8, sum8} !== 9'h100) begin
          failures++; $display("FAIL b2b_result k=%0d got=%0b_%h exp=1_00", k, cout8, sum8);
        end
      end
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random8();
    logic [7:0] ta, tb;
    logic tc;
    logic [8:0] exp;
    int k;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom);
      exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
      start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      k = 1;
      while (!done8 && k < 40) begin @(negedge clk); k++; end
      checks++;
      if (!done8 || k != 9 || {cout8, sum8} !== exp) begin
        failures++;
        $display("FAIL rand8 op=%0d a=%h b=%h cin=%b got done=%b lat=%0d res=%h exp lat=9 res=%h",
                 i, ta, tb, tc, done8, k, {cout8, sum8}, exp);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random16();
    logic [15:0] ta, tb;
    logic tc;
    logic [16:0] exp;
    int k;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ta = 16'($urandom); tb = 16'($urandom); tc = 1'($urandom);
      if (i == 0) begin ta = 16'hFFFF; tb = 16'hFFFF; tc = 1'b1; end
      exp = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
      start16 = 1'b1; a16 = ta; b16 = tb; cin16 = tc;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      k = 1;
      while (!done16 && k < 60) begin @(negedge clk); k++; end
      checks++;
      if (!done16 || k != 17 || {cout16, sum16} !== exp) begin
        failures++;
        $display("FAIL rand16 op=%0d a=%h b=%h cin=%b got done=%b lat=%0d res=%h exp lat=17 res=%h",
                 i, ta, tb, tc, done16, k, {cout16, sum16}, exp);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_random8();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
